// File: rtl/approx_mult_err_accum.sv
// Error-metric stage for approximate multipliers: recomputes the exact product and
// accumulates squared, absolute, max-absolute and nonzero error over a 2^LOG2_SAMPLES window.
module approx_mult_err_accum #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned LOG2_SAMPLES = 8,
   parameter int unsigned ACC_W        = 48
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [WIDTH-1:0]               in_a_i,
   input  logic [WIDTH-1:0]               in_b_i,
   input  logic [2*WIDTH-1:0]             in_approx_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [ACC_W-1:0]               sum_sq_o,
   output logic [2*WIDTH+LOG2_SAMPLES-1:0] sum_abs_o,
   output logic [2*WIDTH-1:0]             max_abs_o,
   output logic [LOG2_SAMPLES:0]          err_cnt_o,
   output logic [ACC_W-1:0]               mse_o
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned SW = 2 * WIDTH + LOG2_SAMPLES;
   localparam int unsigned CW = LOG2_SAMPLES + 1;
   localparam logic [CW-1:0] LastCnt = CW'((2 ** LOG2_SAMPLES) - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, done_q;

   logic            s1_valid_q;
   logic [PW:0]     s1_err_q;
   logic            s2_valid_q;
   logic [2*PW-1:0] s2_sq_q;
   logic [PW-1:0]   s2_abs_q;
   logic            s2_nz_q;

   logic [ACC_W-1:0] sum_sq_q;
   logic [SW-1:0]    sum_abs_q;
   logic [PW-1:0]    max_abs_q;
   logic [CW-1:0]    err_cnt_q;

   logic            accept, clear;
   logic [PW-1:0]   exact;
   logic [PW:0]     err_d, err_neg;
   logic [PW-1:0]   abs_d;
   logic [2*PW-1:0] sq_d;

   assign in_ready_o = (state_q == StRun);
   assign accept     = in_valid_i & in_ready_o;
   assign clear      = start_i & ((state_q == StIdle) | (state_q == StDone));

   assign exact   = PW'(in_a_i) * PW'(in_b_i);
   assign err_d   = {1'b0, in_approx_i} - {1'b0, exact};
   assign err_neg = -s1_err_q;
   // |err| never exceeds 2^PW-1, so the sign bit can be dropped after negation
   assign abs_d   = s1_err_q[PW] ? err_neg[PW-1:0] : s1_err_q[PW-1:0];
   assign sq_d    = (2 * PW)'(abs_d) * (2 * PW)'(abs_d);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastCnt) state_d = StDrain;
            end
         end
         StDrain: begin
            // Last sample leaves S2 on this edge once S1 is empty
            if (!s1_valid_q) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_err_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_sq_q    <= '0;
         s2_abs_q   <= '0;
         s2_nz_q    <= 1'b0;
         sum_sq_q   <= '0;
         sum_abs_q  <= '0;
         max_abs_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= (state_d == StRun) || (state_d == StDrain);
         done_q     <= (state_d == StDone);
         s1_valid_q <= accept;
         if (accept) s1_err_q <= err_d;
         s2_valid_q <= s1_valid_q & ~clear;
         if (s1_valid_q) begin
            s2_sq_q  <= sq_d;
            s2_abs_q <= abs_d;
            s2_nz_q  <= (s1_err_q != '0);
         end
         if (clear) begin
            sum_sq_q  <= '0;
            sum_abs_q <= '0;
            max_abs_q <= '0;
            err_cnt_q <= '0;
         end else if (s2_valid_q) begin
            sum_sq_q  <= sum_sq_q + ACC_W'(s2_sq_q);
            sum_abs_q <= sum_abs_q + SW'(s2_abs_q);
            if (s2_abs_q > max_abs_q) max_abs_q <= s2_abs_q;
            err_cnt_q <= err_cnt_q + CW'(s2_nz_q);
         end
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign sum_sq_o  = sum_sq_q;
   assign sum_abs_o = sum_abs_q;
   assign max_abs_o = max_abs_q;
   assign err_cnt_o = err_cnt_q;
   assign mse_o     = sum_sq_q >> LOG2_SAMPLES;

endmodule

// File: tb/tb_approx_mult_err_accum.sv
// Directed bench for approx_mult_err_accum with N=4; per-window expectations are queued
// when a window is driven and popped when done rises.
module tb_approx_mult_err_accum;

   localparam int unsigned W  = 8;
   localparam int unsigned L  = 2;
   localparam int unsigned AW = 48;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_a, in_b;
   logic [2*W-1:0]    in_approx;
   logic              busy, done;
   logic [AW-1:0]     sum_sq, mse;
   logic [2*W+L-1:0]  sum_abs;
   logic [2*W-1:0]    max_abs;
   logic [L:0]        err_cnt;

   typedef struct {
      logic [63:0] sq;
      logic [63:0] sa;
      logic [63:0] mx;
      logic [63:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   approx_mult_err_accum #(
      .WIDTH        (W),
      .LOG2_SAMPLES (L),
      .ACC_W        (AW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_approx_i (in_approx),
      .busy_o      (busy),
      .done_o      (done),
      .sum_sq_o    (sum_sq),
      .sum_abs_o   (sum_abs),
      .max_abs_o   (max_abs),
      .err_cnt_o   (err_cnt),
      .mse_o       (mse)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_a      = 'x;
      in_b      = 'x;
      in_approx = 'x;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sum_sq"}, 64'(sum_sq), 0);
      check({tag, "_sum_abs"}, 64'(sum_abs), 0);
      check({tag, "_max_abs"}, 64'(max_abs), 0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 0);
      check({tag, "_mse"}, 64'(mse), 0);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_ready"}, 64'(in_ready), 0);
   endtask

   // Called at a negedge; returns at the negedge after the start edge
   task automatic do_start(input string tag);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_start_ready"}, 64'(in_ready), 1);
      check({tag, "_start_busy"}, 64'(busy), 1);
      check({tag, "_start_done"}, 64'(done), 0);
      check({tag, "_start_sum_sq"}, 64'(sum_sq), 0);
      check({tag, "_start_sum_abs"}, 64'(sum_abs), 0);
      check({tag, "_start_max_abs"}, 64'(max_abs), 0);
      check({tag, "_start_err_cnt"}, 64'(err_cnt), 0);
   endtask

   task automatic send(input logic v, input int a, input int b, input int err);
      in_valid = v;
      if (v) begin
         in_a      = W'(a);
         in_b      = W'(b);
         in_approx = (2 * W)'(a * b + err);
      end else begin
         in_a      = 'x;
         in_b      = 'x;
         in_approx = 'x;
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic wait_done(input string tag);
      int   n = 0;
      exp_t e = '{default: '0};
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(done), 1);
      check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 1);
      if (sb.size() > 0) e = sb.pop_front();
      check({tag, "_sum_sq"}, 64'(sum_sq), e.sq);
      check({tag, "_sum_abs"}, 64'(sum_abs), e.sa);
      check({tag, "_max_abs"}, 64'(max_abs), e.mx);
      check({tag, "_err_cnt"}, 64'(err_cnt), e.cnt);
      check({tag, "_mse"}, 64'(mse), e.sq >> L);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_ready"}, 64'(in_ready), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      idle_inputs();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 64'(in_ready), 0);
      check("idle_busy", 64'(busy), 0);

      // Exact products
      sb.push_back('{sq: 0, sa: 0, mx: 0, cnt: 0});
      do_start("exact");
      send(1, 3, 5, 0);
      send(1, 255, 255, 0);
      send(1, 0, 7, 0);
      send(1, 16, 16, 0);
      check("exact_ready_low", 64'(in_ready), 0);
      wait_done("exact");

      // Constant +3 error, with done latency check
      sb.push_back('{sq: 36, sa: 12, mx: 3, cnt: 4});
      do_start("pos3");
      send(1, 3, 5, 3);
      send(1, 10, 20, 3);
      send(1, 255, 254, 3);
      send(1, 1, 1, 3);
      check("pos3_done_lat1", 64'(done), 0);
      @(negedge clk);
      check("pos3_done_lat2", 64'(done), 0);
      @(negedge clk);
      check("pos3_done_lat3", 64'(done), 1);
      wait_done("pos3");

      // Negative worst case; start after DONE must clear the previous window
      sb.push_back('{sq: 64'd4228250625, sa: 65025, mx: 65025, cnt: 1});
      do_start("neg");
      send(1, 255, 255, -65025);
      send(1, 2, 3, 0);
      send(1, 100, 100, 0);
      send(1, 17, 0, 0);
      wait_done("neg");

      // Gaps in in_valid and a fifth sample after the window is full
      sb.push_back('{sq: 10, sa: 6, mx: 2, cnt: 4});
      do_start("gap");
      send(1, 10, 10, 1);
      send(0, 0, 0, 0);
      send(0, 0, 0, 0);
      send(1, 20, 20, -2);
      send(1, 7, 9, 2);
      send(0, 0, 0, 0);
      send(1, 50, 40, -1);
      check("gap_ready_low", 64'(in_ready), 0);
      send(1, 9, 9, 5);
      wait_done("gap");

      // start during RUN is ignored
      sb.push_back('{sq: 4, sa: 4, mx: 1, cnt: 4});
      do_start("midstart");
      send(1, 1, 1, 1);
      send(1, 2, 2, 1);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("midstart_busy", 64'(busy), 1);
      check("midstart_ready", 64'(in_ready), 1);
      check("midstart_sum_sq", 64'(sum_sq), 1);
      send(1, 3, 3, 1);
      send(1, 4, 4, 1);
      wait_done("midstart");

      // Asynchronous reset mid-window
      do_start("rst");
      send(1, 2, 2, 7);
      send(1, 3, 3, 7);
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_sum_sq", 64'(sum_sq), 98);
      check("rst_pre_err_cnt", 64'(err_cnt), 2);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_post_ready", 64'(in_ready), 0);
      check("rst_post_busy", 64'(busy), 0);
      check("rst_post_sum_sq", 64'(sum_sq), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
